// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
//   Iterative multiply/divide sequencer that sits beside the single-cycle ALU.
//   One request is accepted in IDLE. The operand magnitudes are then processed
//   at one bit per cycle for WIDTH cycles: shift/add for MUL and restoring
//   subtract for DIV. A FIXUP cycle applies the result signs, and a one-cycle
//   DONE state presents the result on hi:lo.
//
//   Ports
//     clk    in   1      clock, rising edge
//     rst    in   1      synchronous reset, active-high
//     req    in   1      start request, sampled only in IDLE
//     op     in   2      00 MULU, 01 MULS, 10 DIVU, 11 DIVS
//     a      in   WIDTH  multiplicand / dividend, captured on accept
//     b      in   WIDTH  multiplier / divisor, captured on accept
//     abort  in   1      flush; cancels an operation in CALC/FIXUP
//     busy   out  1      high from the cycle after accept through DONE
//     done   out  1      one-cycle pulse, hi/lo/dz valid
//     hi     out  WIDTH  MUL: product upper half; DIV: remainder
//     lo     out  WIDTH  MUL: product lower half; DIV: quotient
//     dz     out  1      divide-by-zero flag of the last completed op
//
//   Configuration
//     MULDIV_EARLY_OUT_EN : when defined, an accept with b==0 (any op) or
//       a==0 (MUL ops) goes straight to DONE in the next cycle.
// -----------------------------------------------------------------------------
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] acc_r;      // partial product high half / partial remainder
  logic [WIDTH-1:0] work_r;     // multiplier bits / dividend-then-quotient bits
  logic [WIDTH-1:0] opnd_r;     // |multiplicand| / |divisor|
  logic             is_div_r, neg_res_r, neg_rem_r, b_zero_r;

  logic             busy_r, done_r, dz_r;
  logic [WIDTH-1:0] hi_r, lo_r;

  logic             accept_s, early_s;
  logic [WIDTH:0]   mul_sum_s, div_shift_s;
  logic [WIDTH-1:0] div_diff_s, acc_nxt_s, work_nxt_s;
  logic             div_ge_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] fix_hi_s, fix_lo_s;
  logic             fix_dz_s;

  // Magnitude of a value that is treated as signed only when sgn is set.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    mag = (sgn && v[WIDTH-1]) ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  assign accept_s = (state_r == S_IDLE) && req && !abort;

`ifdef MULDIV_EARLY_OUT_EN
  assign early_s = (b == {WIDTH{1'b0}}) || (!op[1] && (a == {WIDTH{1'b0}}));
`else
  assign early_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic. Abort is honoured only in CALC and FIXUP.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_nxt_s = early_s ? S_DONE : S_CALC;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_CALC: begin
        if (abort) begin
          state_nxt_s = S_IDLE;
        end else if (cnt_r == {CW{1'b0}}) begin
          state_nxt_s = S_FIXUP;
        end else begin
          state_nxt_s = S_CALC;
        end
      end
      S_FIXUP: begin
        if (abort) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // One iteration of shift/add multiply or restoring divide.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r} + (work_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {acc_r, work_r[WIDTH-1]};
    div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
    // Only used when div_ge_s holds, in which case the true difference fits WIDTH bits.
    div_diff_s  = div_shift_s[WIDTH-1:0] - opnd_r;
    if (is_div_r) begin
      acc_nxt_s  = div_ge_s ? div_diff_s : div_shift_s[WIDTH-1:0];
      work_nxt_s = {work_r[WIDTH-2:0], div_ge_s};
    end else begin
      acc_nxt_s  = mul_sum_s[WIDTH:1];
      work_nxt_s = {mul_sum_s[0], work_r[WIDTH-1:1]};
    end
  end

  // Sign fixup of the raw magnitude result.
  always_comb begin
    prod_s   = {acc_r, work_r};
    fix_hi_s = acc_r;
    fix_lo_s = work_r;
    fix_dz_s = 1'b0;
    if (is_div_r) begin
      // With a zero divisor, the restoring loop leaves |a| in the remainder.
      // The dividend-sign fixup therefore restores the original a, as required.
      fix_hi_s = neg_rem_r ? ({WIDTH{1'b0}} - acc_r) : acc_r;
      if (b_zero_r) begin
        fix_lo_s = {WIDTH{1'b1}};
      end else begin
        fix_lo_s = neg_res_r ? ({WIDTH{1'b0}} - work_r) : work_r;
      end
      fix_dz_s = b_zero_r;
    end else begin
      if (neg_res_r) begin
        prod_s = {(2*WIDTH){1'b0}} - {acc_r, work_r};
      end else begin
        prod_s = {acc_r, work_r};
      end
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= {CW{1'b0}};
      acc_r     <= {WIDTH{1'b0}};
      work_r    <= {WIDTH{1'b0}};
      opnd_r    <= {WIDTH{1'b0}};
      is_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      b_zero_r  <= 1'b0;
    end else if (accept_s) begin
      cnt_r     <= CW'(WIDTH-1);
      acc_r     <= {WIDTH{1'b0}};
      work_r    <= mag(a, op[0]);
      opnd_r    <= mag(b, op[0]);
      is_div_r  <= op[1];
      neg_res_r <= op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_rem_r <= op[0] && a[WIDTH-1];
      b_zero_r  <= (b == {WIDTH{1'b0}});
    end else if (state_r == S_CALC) begin
      cnt_r  <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
      acc_r  <= acc_nxt_s;
      work_r <= work_nxt_s;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Registered outputs. The result registers change only when an op completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= {WIDTH{1'b0}};
      dz_r   <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != S_IDLE);
      done_r <= (state_nxt_s == S_DONE);
      if ((state_r == S_FIXUP) && !abort) begin
        hi_r <= fix_hi_s;
        lo_r <= fix_lo_s;
        dz_r <= fix_dz_s;
      end
`ifdef MULDIV_EARLY_OUT_EN
      else if (accept_s && early_s) begin
        // MUL by/of zero gives 0. DIV by zero gives lo=all ones and hi=a.
        // DIV of zero by nonzero gives 0.
        hi_r <= (op[1] && (b == {WIDTH{1'b0}})) ? a : {WIDTH{1'b0}};
        lo_r <= (op[1] && (b == {WIDTH{1'b0}})) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        dz_r <= op[1] && (b == {WIDTH{1'b0}});
      end
`endif
      else begin
        hi_r <= hi_r;
        lo_r <= lo_r;
        dz_r <= dz_r;
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;
  assign dz   = dz_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq
//   Self-checking bench for muldiv_seq (WIDTH=32). A cycle-level reference
//   model computes results with plain 64-bit arithmetic and tracks op latency
//   as a countdown. It is compared with the DUT on every negative clock edge.
//   Directed operations pin latencies and results to hand-computed constants.
// -----------------------------------------------------------------------------
module tb_muldiv_seq;
  localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int FULL_LAT = W + 2;
  localparam int DZ_LAT   = EARLY ? 1 : FULL_LAT;

  logic         clk = 1'b0;
  logic         rst, req, abort;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, dz;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .a(a), .b(b), .abort(abort),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dz(dz)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference arithmetic for one operation.
  function automatic void ref_calc(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rdz);
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    rdz = 1'b0;
    rh  = '0;
    rl  = '0;
    case (o)
      2'b00: begin p = {32'h0, x} * {32'h0, y}; rh = p[63:32]; rl = p[31:0]; end
      2'b01: begin p = sx * sy; rh = p[63:32]; rl = p[31:0]; end
      2'b10: begin
        if (y == 0) begin rh = x; rl = '1; rdz = 1'b1; end
        else begin rl = x / y; rh = x % y; end
      end
      default: begin
        if (y == 0) begin rh = x; rl = '1; rdz = 1'b1; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin rl = 32'h8000_0000; rh = '0; end
        else begin q = sx / sy; r = sx % sy; rl = q[31:0]; rh = r[31:0]; end
      end
    endcase
  endfunction

  // Model: compare the current cycle, then advance using this cycle's inputs.
  initial begin
    bit           m_valid = 1'b0;
    bit           m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, p_dz;
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi, p_lo;
    int           m_left = 0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
      if (m_valid) begin
        check("busy", 64'(busy), 64'(m_busy));
        check("done", 64'(done), 64'(m_done));
        check("hi",   64'(hi),   64'(m_hi));
        check("lo",   64'(lo),   64'(m_lo));
        check("dz",   64'(dz),   64'(m_dz));
      end
      if (rst) begin
        m_valid = 1'b1; m_busy = 1'b0; m_done = 1'b0;
        m_hi = '0; m_lo = '0; m_dz = 1'b0; m_left = 0;
      end else if (m_valid) begin
        if (m_done) begin
          m_done = 1'b0; m_busy = 1'b0;
        end else if (m_busy) begin
          if (abort) m_busy = 1'b0;
          else begin
            m_left--;
            if (m_left == 0) begin m_done = 1'b1; m_hi = p_hi; m_lo = p_lo; m_dz = p_dz; end
          end
        end else if (req && !abort) begin
          ref_calc(op, a, b, p_hi, p_lo, p_dz);
          m_busy = 1'b1;
          m_left = (EARLY && (b == 0 || (!op[1] && a == 0))) ? 0 : FULL_LAT - 1;
          if (m_left == 0) begin m_done = 1'b1; m_hi = p_hi; m_lo = p_lo; m_dz = p_dz; end
        end
      end
    end
  end

  // Issue one op, wait for DONE (bounded), and check latency plus literal results.
  task automatic do_op(input string name, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int exp_lat, input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed);
    int lat;
    req = 1'b1; op = o; a = x; b = y;
    step(1);
    req = 1'b0; a = $urandom(); b = $urandom(); op = 2'($urandom_range(0, 3));
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin step(1); lat++; end
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " hi"}, 64'(hi), 64'(eh));
    check({name, " lo"}, 64'(lo), 64'(el));
    check({name, " dz"}, 64'(dz), 64'(ed));
    step(1);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int base;
    rst = 1'b1; req = 1'b0; abort = 1'b0; op = 2'b00; a = '0; b = '0;
    step(2);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi",   64'(hi),   64'd0);
    check("reset lo",   64'(lo),   64'd0);
    check("reset dz",   64'(dz),   64'd0);
    rst = 1'b0;

    do_op("mulu max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, FULL_LAT, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    do_op("muls -3*7", 2'b01, 32'hFFFF_FFFD, 32'd7, FULL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    do_op("divs -7/2", 2'b11, 32'hFFFF_FFF9, 32'd2, FULL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    do_op("divs ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, FULL_LAT, 32'h0000_0000, 32'h8000_0000, 1'b0);
    do_op("divu by 0", 2'b10, 32'h0000_1234, 32'h0, DZ_LAT, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);

    // Abort in CALC: no DONE, results held, and the next request completes normally.
    base = done_seen;
    req = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
    step(1);
    req = 1'b0; a = $urandom(); b = $urandom();
    step(9);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort hi",   64'(hi),   64'h1234);
    check("abort lo",   64'(lo),   64'hFFFF_FFFF);
    check("abort dz",   64'(dz),   64'd1);
    step(1);
    check("abort no done", 64'(done_seen - base), 64'd0);
    do_op("divu 100/7", 2'b10, 32'd100, 32'd7, FULL_LAT, 32'd2, 32'd14, 1'b0);

    // Requests while busy are ignored: exactly one DONE.
    base = done_seen;
    req = 1'b1; op = 2'b00; a = $urandom() | 32'h1; b = $urandom() | 32'h1;
    step(1);
    req = 1'b0;
    step(4);
    req = 1'b1; op = 2'b01; a = $urandom(); b = $urandom();
    step(1);
    req = 1'b0;
    step(14);
    req = 1'b1; op = 2'b11; a = $urandom(); b = $urandom();
    step(1);
    req = 1'b0;
    step(19);
    check("busy req ignored", 64'(done_seen - base), 64'd1);

    // Reset in the middle of an op.
    base = done_seen;
    req = 1'b1; op = 2'b01; a = 32'h0000_0123; b = 32'hFFFF_FF00;
    step(1);
    req = 1'b0;
    step(14);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst hi",   64'(hi),   64'd0);
    check("midrst lo",   64'(lo),   64'd0);
    check("midrst dz",   64'(dz),   64'd0);
    step(30);
    check("midrst no done", 64'(done_seen - base), 64'd0);

    // Random traffic is checked by the model.
    for (int i = 0; i < 3000; i++) begin
      req   = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 599) == 0);
      op    = 2'($urandom_range(0, 3));
      a     = pick();
      b     = pick();
      step(1);
    end
    req = 1'b0; abort = 1'b0; rst = 1'b0;
    step(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
